// File: rtl/fetch_responder_pkg.sv
// Shared fetch-path definitions: word format, cell type tags and the responder FSM encoding.
// The package keeps its established name "lisp" so existing importers stay unchanged.
package lisp;

  localparam int WORD_SIZE = 32;

  // The MSB of every stored word carries the cell type tag.
  localparam logic RAM_TYPE = 1'b0;
  localparam logic M9K_TYPE = 1'b1;

  localparam int FCH_MAX_READ_LAT = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_ACK  = 2'd2,
    RESP    = 2'd3
  } fch_rsp_state_t;

endpackage

// File: rtl/fetch_responder_if.sv
// Fetch bus between the decoder (master) and the responder (slave).
// Handshake: rden/wren are levels held by the master; the slave answers each accepted request with exactly one fch_oen pulse.
interface fetch_responder_if #(
  parameter int ADDR_W = 10
);
  import lisp::*;

  logic                 fch_rden;
  logic                 fch_wren;
  logic [ADDR_W-1:0]    fch_addr_in;
  logic [WORD_SIZE-1:0] fch_data_in;
  logic                 fch_oen;
  logic [WORD_SIZE-1:0] fch_data_out;

  modport master (
    output fch_rden, fch_wren, fch_addr_in, fch_data_in,
    input  fch_oen, fch_data_out
  );

  modport slave (
    input  fch_rden, fch_wren, fch_addr_in, fch_data_in,
    output fch_oen, fch_data_out
  );

endinterface

// File: rtl/fetch_responder_mem_array.sv
// Single-port word store with registered, write-first read; maps onto one M9K block group.
// Contents are deliberately not reset.
module fetch_mem_array
  import lisp::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MEM_DEPTH = 2**ADDR_W,
  parameter int DATA_W    = WORD_SIZE
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // rdata only moves when en is high, so a pending read result stays put while the responder waits.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/fetch_responder.sv
// Target end of the fetch interface: accepts read/write requests, serves them from the word store
// and answers each with a one-cycle fch_oen strobe after a fixed latency.
module fetch_responder
  import lisp::*;
#(
  parameter int ADDR_W    = 10,
  parameter int READ_LAT  = 2,
  parameter int MEM_DEPTH = 2**ADDR_W
) (
  input  logic             comp_clk,
  input  logic             comp_rst,
  fetch_responder_if.slave fch,
  output logic             rsp_busy,
  output logic             rsp_err,
  output fch_rsp_state_t   rsp_state
);

  localparam int              CNT_W    = $clog2(FCH_MAX_READ_LAT);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LAT - 1);

  fch_rsp_state_t       state;
  fch_rsp_state_t       state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic                 rd_oor;
  logic                 in_range;
  logic                 accept_wr;
  logic                 accept_rd;
  logic                 rd_strobe;
  logic                 ack_strobe;
  logic                 cnt_dec;
  logic                 set_err;
  logic                 mem_en;
  logic                 mem_we;
  logic [WORD_SIZE-1:0] mem_rdata;
  logic                 oen_q;
  logic [WORD_SIZE-1:0] data_q;

  assign in_range = ({1'b0, fch.fch_addr_in} < (ADDR_W+1)'(MEM_DEPTH));

  // State register
  always_ff @(posedge comp_clk or posedge comp_rst) begin
    if (comp_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; RESP samples requests exactly like IDLE so held requests chain back to back.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, RESP: begin
        if (fch.fch_wren) begin
          state_nxt = WR_ACK;
        end else if (fch.fch_rden) begin
          state_nxt = RD_WAIT;
        end else begin
          state_nxt = IDLE;
        end
      end
      RD_WAIT: begin
        if (cnt == '0) begin
          state_nxt = RESP;
        end
      end
      WR_ACK:  state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    accept_wr  = 1'b0;
    accept_rd  = 1'b0;
    rd_strobe  = 1'b0;
    ack_strobe = 1'b0;
    cnt_dec    = 1'b0;
    rsp_busy   = (state != IDLE);
    unique case (state)
      IDLE, RESP: begin
        accept_wr = fch.fch_wren;
        accept_rd = fch.fch_rden & ~fch.fch_wren;
      end
      RD_WAIT: begin
        rd_strobe = (cnt == '0);
        cnt_dec   = (cnt != '0);
      end
      WR_ACK:  ack_strobe = 1'b1;
      default: ;
    endcase
  end

  // Both-high requests and out-of-range accesses are flagged but still answered.
  assign set_err = (accept_wr & (fch.fch_rden | ~in_range)) | (accept_rd & ~in_range);
  assign mem_en  = (accept_wr | accept_rd) & in_range;
  assign mem_we  = accept_wr;

  fetch_mem_array #(
    .ADDR_W    (ADDR_W),
    .MEM_DEPTH (MEM_DEPTH),
    .DATA_W    (WORD_SIZE)
  ) u_mem (
    .clk   (comp_clk),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (fch.fch_addr_in),
    .wdata (fch.fch_data_in),
    .rdata (mem_rdata)
  );

  always_ff @(posedge comp_clk or posedge comp_rst) begin
    if (comp_rst) begin
      cnt     <= '0;
      rd_oor  <= 1'b0;
      oen_q   <= 1'b0;
      data_q  <= '0;
      rsp_err <= 1'b0;
    end else begin
      oen_q <= rd_strobe | ack_strobe;
      if (accept_rd) begin
        cnt    <= CNT_INIT;
        rd_oor <= ~in_range;
      end else if (cnt_dec) begin
        cnt <= cnt - 1'b1;
      end
      // The store was not enabled for an out-of-range read, so its stale output is replaced by zero.
      if (rd_strobe) begin
        data_q <= rd_oor ? '0 : mem_rdata;
      end
      if (set_err) begin
        rsp_err <= 1'b1;
      end
    end
  end

  assign fch.fch_oen      = oen_q;
  assign fch.fch_data_out = data_q;
  assign rsp_state        = state;

endmodule
